// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types for the two-requester ALU arbiter: ALU opcode enum,
//            arbiter FSM state enum, data width and a grant-index helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DATA_W = 32;

    // ALU opcodes; any encoding not listed produces a zero result
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SUB  = 4'd8,
        ALU_LUI  = 4'd9,
        ALU_SRA  = 4'd13
    } e_alu_op;

    // Arbiter FSM: accept in IDLE, compute in EXEC, hold result in RESP
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } e_arb_state;

    // Requester index to one-hot strobe
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Purpose  : Purely combinational 32-bit ALU. Shifts use b[4:0]; arithmetic
//            wraps; unknown opcodes return zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import alu_pkg::*;
(
    input  e_alu_op           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    // Operation decode; the default arm covers every unassigned opcode
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_SUB:  y = a - b;
            ALU_LUI:  y = a;
            ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
            default:  y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one ALU between two requesters. One operation in flight;
//            accept -> EXEC -> RESP, result held until the owner consumes it.
//            Round-robin arbitration by default; defining
//            ALU_ARB_FIXED_PRIO_EN switches to fixed priority (requester 0
//            wins) and removes the last-completed pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  e_alu_op           req_op0,
    input  e_alu_op           req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    e_arb_state        state;
    e_arb_state        state_next;
    logic              grant_idx;
    logic              accept;
    logic              rsp_done;
    e_alu_op           op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              g_q;
    logic [DATA_W-1:0] alu_y;

    // The grant index always names a valid requester when any is valid, so
    // any valid bit in IDLE is an acceptance at the next edge.
    assign accept   = (state == ST_IDLE) && (|req_valid);
    assign rsp_done = (state == ST_RESP) && rsp_ready[g_q];

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is valid
    always_comb begin
        grant_idx = ~req_valid[0];
    end
`else
    logic last_done;

    // Remember who completed last; moves only on the response handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_done <= 1'b1;
        end else if (rsp_done) begin
            last_done <= g_q;
        end
    end

    // On a tie grant the requester that did not complete last
    always_comb begin
        grant_idx = req_valid[1];
        if (&req_valid) begin
            grant_idx = ~last_done;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake strobes
    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready  = idx_to_onehot(grant_idx);
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = idx_to_onehot(g_q);
                if (rsp_ready[g_q]) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the granted request at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= ALU_ADD;
            a_q  <= '0;
            b_q  <= '0;
            g_q  <= 1'b0;
        end else if (accept) begin
            op_q <= grant_idx ? req_op1 : req_op0;
            a_q  <= grant_idx ? req_a1  : req_a0;
            b_q  <= grant_idx ? req_b1  : req_b0;
            g_q  <= grant_idx;
        end
    end

    alu u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    // Register the ALU result at the end of EXEC; held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
        end else if (state == ST_EXEC) begin
            rsp_data <= alu_y;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter: vector table plus
//            sequences for arbitration, backpressure and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    e_alu_op     req_op0;
    e_alu_op     req_op1;
    logic [31:0] req_a0;
    logic [31:0] req_b0;
    logic [31:0] req_a1;
    logic [31:0] req_b1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    alu_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          idx;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]  oh;
        logic [31:0] data;
    } sb_t;

    sb_t  sb[$];
    int   total  = 0;
    int   passed = 0;
    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Scoreboard consumer: every response handshake pops one expected item
    always @(negedge clk) begin
        if (rst_n && ((rsp_valid & rsp_ready) != 2'b00)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("sb_rsp_owner", {30'd0, rsp_valid}, {30'd0, e.oh});
                check("sb_rsp_data", rsp_data, e.data);
            end
        end
    end

    // Drive a single request, wait (bounded) for its grant, optionally push
    // the expected response. Returns just after the accepting edge.
    task automatic start_accept(input int idx, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp, input bit push);
        bit got;
        sb_t e;
        got = 1'b0;
        @(posedge clk); #1;
        req_op0 = e_alu_op'(op); req_op1 = e_alu_op'(op);
        req_a0 = a; req_b0 = b; req_a1 = a; req_b1 = b;
        req_valid = (idx == 1) ? 2'b10 : 2'b01;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (req_ready[idx] && req_valid[idx]) begin
                got = 1'b1;
                break;
            end
        end
        check("grant_seen", {31'd0, got}, 32'd1);
        @(posedge clk);
        if (push) begin
            e.oh = (idx == 1) ? 2'b10 : 2'b01;
            e.data = exp;
            sb.push_back(e);
        end
        #1 req_valid = 2'b00;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int accepts;
        int seen;
        sb_t e;

        vecs[0]  = '{0, 4'd0,  32'd5,        32'd7,        32'd12};
        vecs[1]  = '{1, 4'd8,  32'd3,        32'd5,        32'hFFFF_FFFE};
        vecs[2]  = '{0, 4'd13, 32'h8000_0000, 32'd4,       32'hF800_0000};
        vecs[3]  = '{1, 4'd10, 32'd123,      32'd456,      32'd0};
        vecs[4]  = '{0, 4'd2,  32'hFFFF_FFFF, 32'd1,       32'd1};
        vecs[5]  = '{1, 4'd3,  32'hFFFF_FFFF, 32'd1,       32'd0};
        vecs[6]  = '{0, 4'd1,  32'd1,        32'd31,       32'h8000_0000};
        vecs[7]  = '{1, 4'd5,  32'h8000_0000, 32'd36,      32'h0800_0000};
        vecs[8]  = '{0, 4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
        vecs[9]  = '{1, 4'd6,  32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF};
        vecs[10] = '{0, 4'd7,  32'h0000_000F, 32'h0000_003C, 32'h0000_000C};
        vecs[11] = '{1, 4'd9,  32'h1234_5000, 32'h0000_FFFF, 32'h1234_5000};
        vecs[12] = '{0, 4'd0,  32'hFFFF_FFFF, 32'd2,       32'd1};
        vecs[13] = '{1, 4'd13, 32'h7FFF_FFFF, 32'h21,      32'h3FFF_FFFF};
        vecs[14] = '{0, 4'd15, 32'hDEAD_BEEF, 32'd3,       32'd0};

        rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
        req_op0 = ALU_ADD; req_op1 = ALU_ADD;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        #2 rst_n = 1'b0;
        #21;
        check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_req_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Combinational ready, then drop without a handshake
        @(posedge clk); #1 req_valid = 2'b10;
        #1 check("ready_single_req1", {30'd0, req_ready}, 32'h2);
        req_valid = 2'b00;
        @(negedge clk) check("drop_valid_no_effect", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 req_valid = 2'b11;
        #1 check("tie_first_grant_req0", {30'd0, req_ready}, 32'h1);
        req_valid = 2'b00;

        // Both requesters continuously valid for four operations
        @(posedge clk); #1;
        req_op0 = ALU_SUB; req_a0 = 32'd3; req_b0 = 32'd5;
        req_op1 = ALU_SRA; req_a1 = 32'h8000_0000; req_b1 = 32'd4;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            e.oh = 2'b01;
`else
            e.oh = (k % 2 == 1) ? 2'b10 : 2'b01;
`endif
            e.data = (e.oh == 2'b10) ? 32'hF800_0000 : 32'hFFFF_FFFE;
            sb.push_back(e);
        end
        req_valid = 2'b11;
        accepts = 0;
        for (int c = 0; c < 60 && accepts < 4; c++) begin
            @(negedge clk);
            if (!busy && ((req_valid & req_ready) != 2'b00)) begin
                accepts++;
                if (accepts == 4) begin
                    @(posedge clk); #1 req_valid = 2'b00;
                end
            end
        end
        check("rr_accept_count", accepts, 32'd4);
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        check("rr_all_responses", sb.size(), 32'd0);
        wait_idle();

        // Vector table, with latency checks on every operation
        for (int i = 0; i < 15; i++) begin
            start_accept(vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            @(negedge clk);
            check("exec_no_rsp", {30'd0, rsp_valid}, 32'd0);
            @(negedge clk);
            check("latency2_rsp_valid", {30'd0, rsp_valid}, (vecs[i].idx == 1) ? 32'h2 : 32'h1);
            @(posedge clk);
            @(negedge clk);
            check("back_to_idle", {31'd0, busy}, 32'd0);
        end

        // Backpressure: result held five cycles, other inputs ignored
        rsp_ready = 2'b00;
        start_accept(0, 4'd0, 32'd5, 32'd7, 32'd12, 1'b1);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", {30'd0, rsp_valid}, 32'h1);
            check("bp_rsp_data", rsp_data, 32'd12);
            check("bp_req_ready", {30'd0, req_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
            req_valid = 2'b11; req_op0 = ALU_SUB; req_a0 = k; rsp_ready = 2'b10;
            @(negedge clk);
        end
        @(posedge clk); #1 req_valid = 2'b00; rsp_ready = 2'b01;
        @(negedge clk) check("bp_still_resp", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("bp_idle_after_ready", {31'd0, busy}, 32'd0);
        check("bp_rsp_dropped", {30'd0, rsp_valid}, 32'd0);
        rsp_ready = 2'b11;

        // Reset during EXEC abandons the operation
        start_accept(1, 4'd4, 32'h1234_5678, 32'hFFFF_0000, 32'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_mid_rsp_data", rsp_data, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || busy) seen++;
        end
        check("no_rsp_after_reset", seen, 32'd0);

        check("sb_empty_at_end", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 Port rst_n, input, 1: asynchronous active-low reset.
REQ-003 Port req_valid, input, 2: per-requester operation request; bit i belongs to requester i.
REQ-004 Port req_ready, output, 2: per-requester accept strobe; a request is taken when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-005 Port req_op0 / req_op1, input, 4 each (type e_alu_op): ALU operation per requester.
REQ-006 Port req_a0, req_b0, req_a1, req_b1, input, 32 each: operands per requester.
REQ-007 Port rsp_valid, output, 2: result available for requester i.
REQ-008 Port rsp_ready, input, 2: requester i consumes its result.
REQ-009 Port rsp_data, output, 32: registered result, shared by both requesters.
REQ-010 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-012 In IDLE with any req_valid bit high, the block SHALL grant exactly one requester.
REQ-013 In IDLE, req_ready[g] SHALL be high combinationally for the granted requester g only; req_ready SHALL be 0 in all other states.
REQ-014 On acceptance, the block SHALL capture op, a, b and the grant index g, and go IDLE->EXEC.
REQ-015 In EXEC, the block SHALL apply the captured operands to the internal ALU, register the ALU output into rsp_data, and go EXEC->RESP.
REQ-016 In RESP, rsp_valid[g] SHALL be high and rsp_data stable until rsp_ready[g] is high at a clock edge; the block then goes RESP->IDLE.
REQ-017 Latency from the accept edge to rsp_valid high SHALL be 2 cycles; peak throughput SHALL be one operation per 3 cycles.
REQ-018 Arbitration SHALL be round-robin: with both requests valid, grant the requester other than the last-completed one.
REQ-019 The last-completed pointer SHALL update only on the response handshake.
REQ-020 The block SHALL ignore rsp_ready[~g] and all changes on req_* inputs while in EXEC or RESP.
REQ-021 ALU semantics SHALL be as follows (shift amount b[4:0]):
- ADD=0, SLL=1, SLT=2 (signed), SLTU=3, XOR=4, SRL=5, OR=6, AND=7, SUB=8
- LUI=9 passes a
- SRA=13
- any other code yields 0
- all arithmetic is 32-bit with wrap-around and no overflow flag.
REQ-022 A requester SHALL be able to drop req_valid in IDLE without a handshake, with no effect on state.

Reset
REQ-023 On rst_n low, independent of clk, the block SHALL force:
- state IDLE, round-robin pointer = 1 (so requester 0 wins the first tie)
- rsp_data = 0, rsp_valid = 0, busy = 0
- captured op/a/b/g cleared.
REQ-024 Reset during EXEC or RESP SHALL abandon the operation; no response is delivered after reset release.

Configuration
REQ-025 With macro ALU_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: requester 0 always wins a tie, and the pointer logic is removed.
REQ-026 Without ALU_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-018.

Structure
REQ-027 The enum e_alu_op (4-bit, encodings per REQ-021) and the FSM state enum SHALL live in the shared package alu_pkg.
REQ-028 The block SHALL instantiate the existing combinational module alu as its single sub-module; no other sub-modules.

Verification
REQ-029 Single ADD: req0 ADD a=5, b=7.
- Expected: accepted in cycle 0; rsp_valid=2'b01 with rsp_data=12 in cycle 2.
REQ-030 Tie, round-robin: both valid, req0 SUB 3-5, req1 SRA 0x80000000>>>4.
- Expected: first grant to req0 with rsp_data=0xFFFFFFFE; second grant to req1 with rsp_data=0xF8000000.
REQ-031 Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
- Expected: rsp_valid and rsp_data stay stable, req_ready=0, busy=1; IDLE is re-entered one edge after rsp_ready rises.
REQ-032 Reset mid-operation: rst_n low during EXEC.
- Expected: rsp_valid=0, rsp_data=0 and busy=0 immediately; no response afterwards.
REQ-033 Illegal op and SLT:
- op=10 -> rsp_data=0.
- SLT a=0xFFFFFFFF, b=1 -> 1.
- SLTU with the same operands -> 0.
REQ-034 With ALU_ARB_FIXED_PRIO_EN, requester 0 continuously valid for 4 operations -> requester 1 is never granted. Without the macro, grants alternate 0,1,0,1.
